// File: rtl/optic_flow_scheduler_if.sv
// rtl/optic_flow_scheduler_if.sv - CI and scratch-memory bus bundle for the optic-flow scheduler
interface optic_flow_scheduler_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic [7:0]            ciN;
    logic [31:0]           valueA;
    logic [31:0]           valueB;
    logic                  done;
    logic [31:0]           result;
    logic                  memReq;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [31:0]           memWdata;
    logic                  memGrant;
    logic                  memRvalid;
    logic [31:0]           memRdata;
    logic                  irq;

    modport slave (
        input  start, ciN, valueA, valueB, memGrant, memRvalid, memRdata,
        output done, result, memReq, memWe, memAddr, memWdata, irq
    );

    modport master (
        output start, ciN, valueA, valueB, memGrant, memRvalid, memRdata,
        input  done, result, memReq, memWe, memAddr, memWdata, irq
    );
endinterface

// File: rtl/optic_flow_scheduler.sv
// rtl/optic_flow_scheduler.sv - CI-launched engine streaming the optic-flow kernel over scratch buffers
module optic_flow_scheduler #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         ADDR_WIDTH          = 12,
    parameter int         COUNT_WIDTH         = 16
) (
    input logic                   clock,
    input logic                   reset,
    optic_flow_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_CUR, W_CUR, RD_PREV, W_PREV, WR} state_t;

    state_t                 state, state_next;
    logic [ADDR_WIDTH-1:0]  cur_base, prev_base, out_base;
    logic [ADDR_WIDTH-1:0]  cur_ptr, prev_ptr, out_ptr;
    logic [COUNT_WIDTH-1:0] count, progress, progress_inc, launch_n;
    logic [31:0]            cur_word, prev_word, flow, result;
    logic [15:0]            progress_lo;
    logic [2:0]             op;
    logic                   sel, busy, launch, last_word, abort_pending, irq_q;
    logic                   mem_req, mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [31:0]            mem_wdata;
    logic                   unused_bits;

    // Pixel i: x at even bit, y at odd bit of each 16-bit row; D row x bits do not enter the kernel
    function automatic logic [31:0] flow_word(input logic [31:0] c, input logic [31:0] p);
        logic [7:0]  ux, uy, dy, pux, puy, pdy, la, ra, ua, da;
        logic [31:0] r;
        for (int i = 0; i < 8; i++) begin
            ux[i]  = c[16 + 2*i];
            uy[i]  = c[17 + 2*i];
            dy[i]  = c[1 + 2*i];
            pux[i] = p[16 + 2*i];
            puy[i] = p[17 + 2*i];
            pdy[i] = p[1 + 2*i];
        end
        la = ux & (pux >> 1);
        ra = (ux >> 1) & pux;
        ua = uy & pdy;
        da = dy & puy;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = {ua[i] & ~da[i], da[i] & ~ua[i], la[i] & ~ra[i], ra[i] & ~la[i]};
        end
        return r;
    endfunction

    assign sel          = bus.start && (bus.ciN == customInstructionId);
    assign op           = bus.valueA[2:0];
    assign busy         = (state != IDLE);
    assign launch       = sel && (op == 3'd3) && !busy;
    assign launch_n     = bus.valueB[COUNT_WIDTH-1:0];
    assign progress_inc = progress + COUNT_WIDTH'(1);
    assign last_word    = (progress_inc == count);
    assign progress_lo  = 16'(progress);
    assign flow         = flow_word(cur_word, prev_word);
    assign unused_bits  = ^{bus.valueA[31:3], bus.valueB, cur_word, prev_word};

    always_comb begin
        result = 32'd0;
        if (sel) begin
            case (op)
                3'd3:    result = {31'd0, !busy};
                3'd4:    result = {busy, 15'd0, progress_lo};
                default: result = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        case (state)
            IDLE:    if (launch && launch_n != '0) state_next = RD_CUR;
            RD_CUR: begin
                mem_req  = 1'b1;
                mem_addr = cur_ptr;
                if (bus.memGrant) state_next = W_CUR;
            end
            W_CUR:   if (bus.memRvalid) state_next = RD_PREV;
            RD_PREV: begin
                mem_req  = 1'b1;
                mem_addr = prev_ptr;
                if (bus.memGrant) state_next = W_PREV;
            end
            W_PREV:  if (bus.memRvalid) state_next = WR;
            WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = out_ptr;
                mem_wdata = flow;
                if (bus.memGrant) state_next = (last_word || abort_pending) ? IDLE : RD_CUR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_base      <= '0;
            prev_base     <= '0;
            out_base      <= '0;
            cur_ptr       <= '0;
            prev_ptr      <= '0;
            out_ptr       <= '0;
            count         <= '0;
            progress      <= '0;
            cur_word      <= 32'd0;
            prev_word     <= 32'd0;
            abort_pending <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (sel) begin
                case (op)
                    3'd0:    cur_base  <= bus.valueB[ADDR_WIDTH-1:0];
                    3'd1:    prev_base <= bus.valueB[ADDR_WIDTH-1:0];
                    3'd2:    out_base  <= bus.valueB[ADDR_WIDTH-1:0];
                    3'd5:    if (busy) abort_pending <= 1'b1;
                    default: ;
                endcase
            end
            if (!busy) abort_pending <= 1'b0;
            // Bases are copied here so base writes during a run never move the live pointers
            if (launch) begin
                count    <= launch_n;
                cur_ptr  <= cur_base;
                prev_ptr <= prev_base;
                out_ptr  <= out_base;
                if (launch_n == '0) irq_q    <= 1'b1;
                else                progress <= '0;
            end
            if (state == W_CUR && bus.memRvalid)  cur_word  <= bus.memRdata;
            if (state == W_PREV && bus.memRvalid) prev_word <= bus.memRdata;
            if (state == WR && bus.memGrant) begin
                cur_ptr  <= cur_ptr + ADDR_WIDTH'(1);
                prev_ptr <= prev_ptr + ADDR_WIDTH'(1);
                out_ptr  <= out_ptr + ADDR_WIDTH'(1);
                progress <= progress_inc;
                if (last_word) irq_q <= 1'b1;
            end
        end
    end

    assign bus.done     = sel;
    assign bus.result   = result;
    assign bus.memReq   = mem_req;
    assign bus.memWe    = mem_we;
    assign bus.memAddr  = mem_addr;
    assign bus.memWdata = mem_wdata;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_optic_flow_scheduler.sv
// tb/tb_optic_flow_scheduler.sv - self-checking bench for optic_flow_scheduler
module tb_optic_flow_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    optic_flow_scheduler_if #(.ADDR_WIDTH(12)) bus();

    optic_flow_scheduler #(
        .customInstructionId(8'd0),
        .ADDR_WIDTH(12),
        .COUNT_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mem [0:4095];
    int unsigned rd_q[$];
    int unsigned wr_a_q[$];
    logic [31:0] wr_d_q[$];
    int stall = 0;
    int age = 0;
    int irq_cnt = 0;
    int stab_err = 0;
    int hold_cnt = 0;
    int req_cnt = 0;
    logic pend = 1'b0;
    logic [11:0] p_addr;
    logic p_we;
    logic [31:0] p_wdata;
    logic [31:0] basic_data [2];

    assign bus.memGrant = (stall == 0) ? 1'b1 : (bus.memReq && age >= stall);

    // Scratch memory: read data returns exactly one cycle after a granted read
    always @(posedge clock) begin
        bus.memRvalid <= 1'b0;
        if (bus.memReq && bus.memGrant) begin
            age <= 0;
            if (bus.memWe) begin
                mem[bus.memAddr] <= bus.memWdata;
                wr_a_q.push_back(int'(bus.memAddr));
                wr_d_q.push_back(bus.memWdata);
            end else begin
                bus.memRvalid <= 1'b1;
                bus.memRdata  <= mem[bus.memAddr];
                rd_q.push_back(int'(bus.memAddr));
            end
        end else if (bus.memReq) begin
            age <= age + 1;
        end else begin
            age <= 0;
        end
    end

    always @(negedge clock) begin
        if (bus.irq) irq_cnt++;
        if (bus.memReq) req_cnt++;
        if (bus.memReq && !bus.memGrant) hold_cnt++;
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pend && (!bus.memReq || bus.memAddr !== p_addr || bus.memWe !== p_we || bus.memWdata !== p_wdata))
                stab_err++;
            pend    = bus.memReq && !bus.memGrant;
            p_addr  = bus.memAddr;
            p_we    = bus.memWe;
            p_wdata = bus.memWdata;
        end
    end

    // Reference kernel evaluated pixel by pixel from the written rules
    function automatic logic [31:0] ref_flow(input logic [31:0] c, input logic [31:0] p);
        logic [31:0] r;
        int ux, uxn, pux, puxn, uy, dy, puy, pdy, la, ra, ua, da, nib;
        r = 32'd0;
        for (int i = 0; i < 8; i++) begin
            ux   = int'((c >> (16 + 2*i)) & 32'd1);
            uxn  = int'((c >> (18 + 2*i)) & 32'd1);
            pux  = int'((p >> (16 + 2*i)) & 32'd1);
            puxn = int'((p >> (18 + 2*i)) & 32'd1);
            uy   = int'((c >> (17 + 2*i)) & 32'd1);
            dy   = int'((c >> (1 + 2*i)) & 32'd1);
            puy  = int'((p >> (17 + 2*i)) & 32'd1);
            pdy  = int'((p >> (1 + 2*i)) & 32'd1);
            la = ux & puxn;
            ra = uxn & pux;
            ua = uy & pdy;
            da = dy & puy;
            nib = 8 * (ua & (1 - da)) + 4 * (da & (1 - ua)) + 2 * (la & (1 - ra)) + (ra & (1 - la));
            r = r | (32'(nib) << (4*i));
        end
        return r;
    endfunction

    task automatic ci(input logic [2:0] op, input logic [31:0] b, output logic [31:0] r, output logic d);
        @(negedge clock);
        bus.start  = 1'b1;
        bus.ciN    = 8'd0;
        bus.valueA = {29'd0, op};
        bus.valueB = b;
        #1;
        r = bus.result;
        d = bus.done;
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.valueA = 32'd0;
        bus.valueB = 32'd0;
    endtask

    task automatic wait_idle(input int max_polls, output logic ok, output logic [31:0] st);
        logic [31:0] r;
        logic d;
        ok = 1'b0;
        st = 32'd0;
        for (int i = 0; i < max_polls; i++) begin
            ci(3'd4, 32'd0, r, d);
            if (!r[31]) begin
                ok = 1'b1;
                st = r;
                break;
            end
        end
    endtask

    task automatic run_job(input int cb, input int pb, input int ob, input int n, input int st_val,
                           output logic [31:0] status);
        logic [31:0] r;
        logic d, ok;
        stall = st_val;
        rd_q.delete();
        wr_a_q.delete();
        wr_d_q.delete();
        ci(3'd0, cb, r, d);
        ci(3'd1, pb, r, d);
        ci(3'd2, ob, r, d);
        ci(3'd3, n, r, d);
        n_total++;
        if (r !== 32'd1) $display("FAIL launch_ack got %h want 00000001", r);
        else n_pass++;
        wait_idle(2000, ok, status);
        n_total++;
        if (ok !== 1'b1) $display("FAIL run_timeout got busy want idle");
        else n_pass++;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        logic d;
        n_total++;
        if ({bus.done, bus.memReq, bus.memWe, bus.irq} !== 4'b0 || bus.result !== 32'd0 || bus.memAddr !== 12'd0 || bus.memWdata !== 32'd0)
            $display("FAIL reset_outputs got done=%b req=%b we=%b irq=%b result=%h want all 0", bus.done, bus.memReq, bus.memWe, bus.irq, bus.result);
        else n_pass++;
        @(negedge clock);
        bus.start  = 1'b1;
        bus.ciN    = 8'd5;
        bus.valueA = 32'd4;
        #1;
        n_total++;
        if (bus.done !== 1'b0 || bus.result !== 32'd0) $display("FAIL unselected_ci got done=%b result=%h want 0/0", bus.done, bus.result);
        else n_pass++;
        bus.start = 1'b0;
        ci(3'd4, 32'd0, r, d);
        n_total++;
        if (d !== 1'b1 || r !== 32'd0) $display("FAIL reset_status got done=%b result=%h want 1/00000000", d, r);
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [31:0] st;
        int exp_rd [4];
        int i0;
        exp_rd = '{16, 32, 17, 33};
        for (int k = 0; k < 2; k++) begin
            mem[16 + k] = $urandom;
            mem[32 + k] = $urandom;
        end
        i0 = irq_cnt;
        run_job(16, 32, 48, 2, 0, st);
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (k >= rd_q.size() || rd_q[k] != exp_rd[k]) $display("FAIL basic_read%0d got %0h want %0h", k, (k < rd_q.size()) ? rd_q[k] : 32'hffff, exp_rd[k]);
            else n_pass++;
        end
        for (int k = 0; k < 2; k++) begin
            basic_data[k] = ref_flow(mem[16 + k], mem[32 + k]);
            n_total++;
            if (k >= wr_a_q.size() || wr_a_q[k] != 48 + k || wr_d_q[k] !== basic_data[k])
                $display("FAIL basic_write%0d got %0h:%h want %0h:%h", k, (k < wr_a_q.size()) ? wr_a_q[k] : 32'hffff, (k < wr_d_q.size()) ? wr_d_q[k] : 32'hx, 48 + k, basic_data[k]);
            else n_pass++;
        end
        n_total++;
        if (irq_cnt - i0 != 1) $display("FAIL basic_irq got %0d pulses want 1", irq_cnt - i0);
        else n_pass++;
        n_total++;
        if (st !== 32'h0000_0002) $display("FAIL basic_status got %h want 00000002", st);
        else n_pass++;
    endtask

    task automatic test_stall;
        logic [31:0] st;
        int e0, h0;
        e0 = stab_err;
        h0 = hold_cnt;
        run_job(16, 32, 48, 2, 7, st);
        stall = 0;
        n_total++;
        if (stab_err != e0) $display("FAIL stall_stability got %0d changes want 0", stab_err - e0);
        else n_pass++;
        n_total++;
        if (hold_cnt - h0 != 42) $display("FAIL stall_hold_cycles got %0d want 42", hold_cnt - h0);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (k >= wr_d_q.size() || wr_d_q[k] !== basic_data[k] || wr_a_q[k] != 48 + k)
                $display("FAIL stall_write%0d got %h want %h", k, (k < wr_d_q.size()) ? wr_d_q[k] : 32'hx, basic_data[k]);
            else n_pass++;
        end
        n_total++;
        if (st !== 32'h0000_0002) $display("FAIL stall_status got %h want 00000002", st);
        else n_pass++;
    endtask

    task automatic test_flow_dirs;
        logic [31:0] vc [5];
        logic [31:0] vp [5];
        logic [31:0] ve [5];
        logic [31:0] st;
        vc = '{32'h0002_0000, 32'h0000_0002, 32'h0001_0000, 32'h0004_0000, 32'h0005_0000};
        vp = '{32'h0000_0002, 32'h0002_0000, 32'h0004_0000, 32'h0001_0000, 32'h0005_0000};
        ve = '{32'h0000_0008, 32'h0000_0004, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        for (int i = 0; i < 5; i++) begin
            mem[256] = vc[i];
            mem[512] = vp[i];
            run_job(256, 512, 768, 1, 0, st);
            n_total++;
            if (wr_d_q.size() != 1 || wr_d_q[0] !== ve[i])
                $display("FAIL flow_dir%0d got %h want %h", i, (wr_d_q.size() > 0) ? wr_d_q[0] : 32'hx, ve[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [31:0] st, exp;
        int cb, pb, ob, n, i0;
        for (int it = 0; it < 5; it++) begin
            cb = (it == 4) ? 4094 : int'($urandom_range(0, 1023));
            pb = 1024 + int'($urandom_range(0, 1000));
            ob = 2048 + int'($urandom_range(0, 1000));
            n  = (it == 4) ? 4 : int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) begin
                mem[(cb + k) % 4096] = $urandom;
                mem[(pb + k) % 4096] = $urandom;
            end
            i0 = irq_cnt;
            run_job(cb, pb, ob, n, int'($urandom_range(0, 3)), st);
            stall = 0;
            for (int k = 0; k < n; k++) begin
                exp = ref_flow(mem[(cb + k) % 4096], mem[(pb + k) % 4096]);
                n_total++;
                if (2*k + 1 >= rd_q.size() || rd_q[2*k] != (cb + k) % 4096 || rd_q[2*k + 1] != (pb + k) % 4096)
                    $display("FAIL rand%0d_read%0d got %0h/%0h want %0h/%0h", it, k, (2*k < rd_q.size()) ? rd_q[2*k] : 32'hffff,
                             (2*k + 1 < rd_q.size()) ? rd_q[2*k + 1] : 32'hffff, (cb + k) % 4096, (pb + k) % 4096);
                else n_pass++;
                n_total++;
                if (k >= wr_d_q.size() || wr_a_q[k] != ob + k || wr_d_q[k] !== exp)
                    $display("FAIL rand%0d_write%0d got %h want %h", it, k, (k < wr_d_q.size()) ? wr_d_q[k] : 32'hx, exp);
                else n_pass++;
            end
            n_total++;
            if (st !== 32'(n) || irq_cnt - i0 != 1) $display("FAIL rand%0d_end got status=%h irqs=%0d want %h/1", it, st, irq_cnt - i0, 32'(n));
            else n_pass++;
        end
    endtask

    task automatic test_busy_abort;
        logic [31:0] r, st, exp;
        logic d, ok;
        int i0, k0, nw;
        for (int k = 0; k < 16; k++) begin
            mem[64 + k] = $urandom;
            mem[80 + k] = $urandom;
        end
        stall = 0;
        rd_q.delete();
        wr_a_q.delete();
        wr_d_q.delete();
        i0 = irq_cnt;
        ci(3'd0, 64, r, d);
        ci(3'd1, 80, r, d);
        ci(3'd2, 96, r, d);
        ci(3'd3, 3, r, d);
        ci(3'd3, 7, r, d);
        n_total++;
        if (r !== 32'd0) $display("FAIL busy_launch got %h want 00000000", r);
        else n_pass++;
        ci(3'd1, 32'h700, r, d);
        wait_idle(2000, ok, st);
        n_total++;
        if (!ok || st !== 32'd3 || irq_cnt - i0 != 1) $display("FAIL busy_run got status=%h irqs=%0d want 00000003/1", st, irq_cnt - i0);
        else n_pass++;
        n_total++;
        if (rd_q.size() != 6 || rd_q[5] != 82 || rd_q[4] != 66) $display("FAIL busy_ptrs got size=%0d want reads ending 42/52", rd_q.size());
        else n_pass++;

        ci(3'd1, 80, r, d);
        rd_q.delete();
        wr_a_q.delete();
        wr_d_q.delete();
        i0 = irq_cnt;
        ci(3'd3, 10, r, d);
        repeat (12) @(posedge clock);
        @(negedge clock);
        k0 = wr_a_q.size();
        ci(3'd5, 0, r, d);
        wait_idle(2000, ok, st);
        nw = wr_a_q.size();
        n_total++;
        if (!ok || irq_cnt != i0) $display("FAIL abort_end got idle=%b irqs=%0d want 1/0", ok, irq_cnt - i0);
        else n_pass++;
        n_total++;
        if (nw <= k0 || nw > k0 + 2 || nw >= 10 || st !== 32'(nw))
            $display("FAIL abort_count got writes=%0d status=%h want %0d..%0d and matching", nw, st, k0 + 1, k0 + 2);
        else n_pass++;
        for (int k = 0; k < nw; k++) begin
            exp = ref_flow(mem[64 + k], mem[80 + k]);
            n_total++;
            if (wr_d_q[k] !== exp || wr_a_q[k] != 96 + k) $display("FAIL abort_write%0d got %h want %h", k, wr_d_q[k], exp);
            else n_pass++;
        end
    endtask

    task automatic test_zero_launch;
        logic [31:0] r;
        logic d;
        int q0, i0;
        q0 = req_cnt;
        i0 = irq_cnt;
        ci(3'd3, 0, r, d);
        n_total++;
        if (r !== 32'd1 || bus.irq !== 1'b1) $display("FAIL zero_launch got result=%h irq=%b want 00000001/1", r, bus.irq);
        else n_pass++;
        @(posedge clock);
        #1;
        n_total++;
        if (bus.irq !== 1'b0) $display("FAIL zero_irq_width got irq=%b want 0", bus.irq);
        else n_pass++;
        repeat (3) @(posedge clock);
        ci(3'd4, 0, r, d);
        n_total++;
        if (req_cnt != q0 || irq_cnt - i0 != 1 || r[31] !== 1'b0) $display("FAIL zero_quiet got reqs=%0d irqs=%0d busy=%b want 0/1/0", req_cnt - q0, irq_cnt - i0, r[31]);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        logic d, found;
        stall = 2;
        ci(3'd0, 16, r, d);
        ci(3'd1, 32, r, d);
        ci(3'd2, 48, r, d);
        ci(3'd3, 4, r, d);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.memReq && bus.memWe) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (!found) $display("FAIL reset_mid_reach got no WR want WR");
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.memReq !== 1'b0 || bus.memWe !== 1'b0) $display("FAIL reset_mid_req got req=%b we=%b want 0/0", bus.memReq, bus.memWe);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        stall = 0;
        ci(3'd4, 0, r, d);
        n_total++;
        if (r !== 32'd0) $display("FAIL reset_mid_status got %h want 00000000", r);
        else n_pass++;
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.ciN    = 8'd0;
        bus.valueA = 32'd0;
        bus.valueB = 32'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_flow_dirs();
        test_random();
        test_busy_abort();
        test_zero_launch();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
